// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller command port between two bus masters.
// Master 0 is the cache controller, master 1 a secondary client (DMA/debug).
// The port is granted per burst with round-robin arbitration, followed by one
// dead turnaround cycle between owners. A watchdog revokes a stalled grant.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   mX_req                   master X requests the port for a burst
//   mX_addr/wr_rd/mstrb      master X beat address, direction, beat strobe
//   mX_gnt                   master X owns the port (registered)
//   sdram_add/wr_rd/mstrb    muxed command to the SDRAM controller
//   busy                     port owned or in turnaround (registered)
//   owner                    index of the last or current owner (registered)
//   err_timeout              one-cycle pulse when the watchdog releases a grant
module sdram_port_arbiter #(
    parameter int unsigned BURST_LEN    = 32,
    parameter int unsigned IDLE_TIMEOUT = 64,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_wr_rd,
    input  logic              m0_mstrb,
    output logic              m0_gnt,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wr_rd,
    input  logic              m1_mstrb,
    output logic              m1_gnt,
    output logic [ADDR_W-1:0] sdram_add,
    output logic              sdram_wr_rd,
    output logic              sdram_mstrb,
    output logic              busy,
    output logic              owner,
    output logic              err_timeout
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_GRANT      = 2'd1,
        ST_TURNAROUND = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              m0_gnt_q, m0_gnt_d;
    logic              m1_gnt_q, m1_gnt_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic              cur_req;
    logic              cur_strb;
    logic              pick;

    // Port mux keyed on the registered owner; strobe gated by that owner's grant.
    assign cur_req     = owner_q ? m1_req : m0_req;
    assign cur_strb    = owner_q ? (m1_mstrb & m1_gnt_q) : (m0_mstrb & m0_gnt_q);
    assign sdram_mstrb = cur_strb;
    assign sdram_add   = (m0_gnt_q | m1_gnt_q) ? (owner_q ? m1_addr : m0_addr) : '0;
    assign sdram_wr_rd = (m0_gnt_q | m1_gnt_q) ? (owner_q ? m1_wr_rd : m0_wr_rd) : 1'b0;

    assign m0_gnt      = m0_gnt_q;
    assign m1_gnt      = m1_gnt_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign err_timeout = err_q;

    // State and registered outputs; owner resets to 1 so master 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b1;
            m0_gnt_q <= 1'b0;
            m1_gnt_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            beat_q   <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            m0_gnt_q <= m0_gnt_d;
            m1_gnt_q <= m1_gnt_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
        end
    end

    // Arbitration, burst accounting and release conditions.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        m0_gnt_d = m0_gnt_q;
        m1_gnt_d = m1_gnt_q;
        busy_d   = busy_q;
        err_d    = 1'b0;
        beat_d   = beat_q;
        idle_d   = idle_q;
        pick     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                beat_d = '0;
                idle_d = '0;
                if (m0_req || m1_req) begin
                    // On contention the master that did not own last time wins.
                    pick     = (m0_req && m1_req) ? ~owner_q : m1_req;
                    owner_d  = pick;
                    m0_gnt_d = ~pick;
                    m1_gnt_d = pick;
                    busy_d   = 1'b1;
                    state_d  = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (cur_strb) begin
                    if (beat_q != '1) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                    idle_d = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + IDLE_W'(1);
                end

                // Full burst, early release, or watchdog expiry ends the grant.
                if ((cur_strb && (beat_q == BEAT_LAST)) || !cur_req ||
                    (!cur_strb && (idle_q == IDLE_LAST))) begin
                    err_d    = cur_req && !cur_strb && (idle_q == IDLE_LAST);
                    m0_gnt_d = 1'b0;
                    m1_gnt_d = 1'b0;
                    state_d  = ST_TURNAROUND;
                end
            end

            ST_TURNAROUND: begin
                m0_gnt_d = 1'b0;
                m1_gnt_d = 1'b0;
                beat_d   = '0;
                idle_d   = '0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end

            default: begin
                m0_gnt_d = 1'b0;
                m1_gnt_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule
